// File: rtl/count_pulse_gen.sv
// Button conditioner: 2-flop synchronizer, stability debounce and rising-edge pulse
// generator. Define COUNT_PULSE_GEN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module count_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic count,
   output logic pressed
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) ||
       REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
      $error("count_pulse_gen: illegal parameter combination");
   end

   logic             sync0;
   logic             sync1;
   logic             db_level;
   logic [CNT_W-1:0] deb_cnt;
   logic             rise;
   logic             fall;

   // rise/fall mark the edge on which the debounced level is about to flip
   assign rise = sync1 & ~db_level & (deb_cnt == DEB_LAST);
   assign fall = ~sync1 & db_level & (deb_cnt == DEB_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync0    <= 1'b0;
         sync1    <= 1'b0;
         db_level <= 1'b0;
         deb_cnt  <= '0;
      end else begin
         sync0 <= btn_in;
         sync1 <= sync0;
         if (sync1 == db_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            db_level <= sync1;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign pressed = db_level;

`ifdef COUNT_PULSE_GEN_AUTOREPEAT_EN
   localparam logic [15:0] REP_DELAY  = 16'(REPEAT_DELAY);
   localparam logic [15:0] REP_RELOAD = 16'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [15:0] rep_cnt;
   logic        rep_fire;

   // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart;
   // a repeat coinciding with the release flip is suppressed.
   assign rep_fire = db_level & ~fall & ((rep_cnt + 16'd1) == REP_DELAY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt <= '0;
         count   <= 1'b0;
      end else begin
         count <= rise | rep_fire;
         if (!db_level || fall) begin
            rep_cnt <= '0;
         end else if (rep_fire) begin
            rep_cnt <= REP_RELOAD;
         end else begin
            rep_cnt <= rep_cnt + 16'd1;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 1'b0;
      end else begin
         count <= rise;
      end
   end
`endif

endmodule

// File: tb/tb_count_pulse_gen.sv
// Bench for count_pulse_gen: vector table for press/bounce/glitch plus sequences
// for reset aborts and long holds (auto-repeat aware).
module tb_count_pulse_gen;

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   logic btn_in  = 1'b0;
   logic count, pressed;
   logic count1, pressed1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic btn;
      logic exp_pressed;
      logic exp_count;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] hist;
   int         n;
   logic       exp_rep;

   count_pulse_gen dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .count(count), .pressed(pressed)
   );

   // Second instance at the minimum debounce length, checked against a delay-line model
   count_pulse_gen #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .btn_in(btn_in), .count(count1), .pressed(pressed1)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors + 1);
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic btn, input logic rst_val);
      btn_in = btn;
      reset  = rst_val;
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input int rep, input logic b, input logic p, input logic c);
      vec_t v;
      v.btn = b;
      v.exp_pressed = p;
      v.exp_count = c;
      for (int i = 0; i < rep; i++) vecs.push_back(v);
   endtask

   initial begin
      // idle
      addVec(5, 1'b0, 1'b0, 1'b0);
      // clean press: pulse after the 6th edge, then hold
      addVec(5, 1'b1, 1'b0, 1'b0);
      addVec(1, 1'b1, 1'b1, 1'b1);
      addVec(6, 1'b1, 1'b1, 1'b0);
      // release
      addVec(5, 1'b0, 1'b1, 1'b0);
      addVec(2, 1'b0, 1'b0, 1'b0);
      // bounce 1,0,1,1,0 then stable high from the 6th sample
      addVec(1, 1'b1, 1'b0, 1'b0);
      addVec(1, 1'b0, 1'b0, 1'b0);
      addVec(2, 1'b1, 1'b0, 1'b0);
      addVec(1, 1'b0, 1'b0, 1'b0);
      addVec(5, 1'b1, 1'b0, 1'b0);
      addVec(1, 1'b1, 1'b1, 1'b1);
      addVec(3, 1'b1, 1'b1, 1'b0);
      addVec(5, 1'b0, 1'b1, 1'b0);
      addVec(2, 1'b0, 1'b0, 1'b0);
      // 3-cycle glitch must be rejected
      addVec(3, 1'b1, 1'b0, 1'b0);
      addVec(5, 1'b0, 1'b0, 1'b0);

      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput("reset_count", 16'(count), 16'd0);
         checkOutput("reset_pressed", 16'(pressed), 16'd0);
      end

      hist = '0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].btn, 1'b1);
         hist = {hist[2:0], vecs[i].btn};
         checkOutput($sformatf("vec%0d_pressed", i), 16'(pressed), 16'(vecs[i].exp_pressed));
         checkOutput($sformatf("vec%0d_count", i), 16'(count), 16'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d_pressed_d1", i), 16'(pressed1), 16'(hist[2]));
         checkOutput($sformatf("vec%0d_count_d1", i), 16'(count1), 16'(hist[2] & ~hist[3]));
      end
      checkOutput("glitch_deb_cnt", 16'(dut.deb_cnt), 16'd0);

      // reset in the middle of debouncing a press
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
      checkOutput("mid_deb_cnt", 16'(dut.deb_cnt), 16'd2);
      #2 reset = 1'b0;
      #1;
      checkOutput("abort_count", 16'(count), 16'd0);
      checkOutput("abort_pressed", 16'(pressed), 16'd0);
      checkOutput("abort_deb_cnt", 16'(dut.deb_cnt), 16'd0);
      applyStimulus(1'b1, 1'b0);

      n = 0;
      do begin
         applyStimulus(1'b1, 1'b1);
         n++;
      end while (count !== 1'b1 && n < 20);
      checkOutput("fresh_latency", 16'(n), 16'd6);

      // long hold: single pulse, or repeats at +16, +24, ... with auto-repeat
      for (int k = 1; k <= 50; k++) begin
         applyStimulus(1'b1, 1'b1);
`ifdef COUNT_PULSE_GEN_AUTOREPEAT_EN
         exp_rep = (k >= 16) && ((k - 16) % 8 == 0);
`else
         exp_rep = 1'b0;
`endif
         checkOutput($sformatf("hold_count_%0d", k), 16'(count), 16'(exp_rep));
      end
      checkOutput("hold_pressed", 16'(pressed), 16'd1);

      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput($sformatf("release_count_%0d", k), 16'(count), 16'd0);
      end
      checkOutput("release_pressed", 16'(pressed), 16'd0);

      // reset while the pulse is high
      n = 0;
      do begin
         applyStimulus(1'b1, 1'b1);
         n++;
      end while (count !== 1'b1 && n < 20);
      checkOutput("second_latency", 16'(n), 16'd6);
      #2 reset = 1'b0;
      #1;
      checkOutput("pulse_abort_count", 16'(count), 16'd0);
      checkOutput("pulse_abort_pressed", 16'(pressed), 16'd0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("post_reset_count", 16'(count), 16'd0);
         checkOutput("post_reset_pressed", 16'(pressed), 16'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
